// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive deframer.
package eth_pkg;

    localparam int unsigned ETH_HDR_LEN  = 14;
    localparam int unsigned ETH_DST_OFS  = 0;
    localparam int unsigned ETH_TYPE_OFS = 12;
    localparam int unsigned ETH_MAC_LEN  = 6;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DROP
    } eth_rx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_rx_dpram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
module eth_rx_dpram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        o_rdata <= mem[i_raddr];
    end

endmodule

// File: rtl/eth_rx_deframer.sv
// Ethernet RX deframer: header strip/filter into a commit/rollback show-ahead byte FIFO.
// Optional frame statistics counters are enabled by defining ETH_RX_STATS_EN.
module eth_rx_deframer
    import eth_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [47:0] MY_MAC    = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_rx_sof,
    input  logic        i_rx_eof,
    input  logic        i_rx_err,
    output logic [7:0]  o_rdata,
    output logic        o_rready,
    input  logic        i_rreq,
    output logic        o_drop,
    output logic [15:0] o_drop_cnt,
    output logic [15:0] o_good_cnt
);

    localparam int unsigned DEPTH    = 2**ADDR_W;
    localparam logic [3:0]  MAC_END  = 4'(ETH_DST_OFS + ETH_MAC_LEN);
    localparam logic [3:0]  TYPE_HI  = 4'(ETH_TYPE_OFS);
    localparam logic [3:0]  HDR_LAST = 4'(ETH_HDR_LEN - 1);

    typedef logic [ADDR_W:0] ptr_t;

    eth_rx_state_e state_q, state_d;
    logic [3:0]    hcnt_q, hcnt_d;
    logic          mac_ok_q, mac_ok_d;
    logic          bc_ok_q, bc_ok_d;
    ptr_t          wr_q, wr_d;
    ptr_t          commit_q, commit_d;
    ptr_t          rd_q, rd_d;
    logic          drop_q, drop_d;
    logic          rdy_q;
    logic          ram_we;
    logic [7:0]    ram_q;
    logic          full;
    logic          pop;

    function automatic logic [7:0] mac_byte(input logic [3:0] idx);
        logic [47:0] sh;
        sh = MY_MAC << (8 * idx);
        return sh[47:40];
    endfunction

    assign full = (wr_q - rd_q) == ptr_t'(DEPTH);
    assign pop  = i_rreq & rdy_q;
    assign rd_d = rd_q + ptr_t'(pop);

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        mac_ok_d = mac_ok_q;
        bc_ok_d  = bc_ok_q;
        wr_d     = wr_q;
        commit_d = commit_q;
        drop_d   = 1'b0;
        ram_we   = 1'b0;
        if (i_rx_valid) begin
            if (i_rx_sof) begin
                // sof always restarts: abort any frame in flight, this byte is header byte 0
                drop_d   = (state_q != IDLE);
                wr_d     = commit_q;
                hcnt_d   = 4'd1;
                mac_ok_d = (i_rx_data == mac_byte(4'd0));
                bc_ok_d  = (i_rx_data == 8'hFF);
                if (i_rx_eof) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end else if (!mac_ok_d && !bc_ok_d) begin
                    state_d = DROP;
                end else begin
                    state_d = HDR;
                end
            end else begin
                case (state_q)
                    HDR: begin
                        hcnt_d = hcnt_q + 4'd1;
                        if (hcnt_q < MAC_END) begin
                            mac_ok_d = mac_ok_q && (i_rx_data == mac_byte(hcnt_q));
                            bc_ok_d  = bc_ok_q && (i_rx_data == 8'hFF);
                        end
                        if (i_rx_eof) begin
                            drop_d  = 1'b1;
                            state_d = IDLE;
                        end else if (!mac_ok_d && !bc_ok_d) begin
                            state_d = DROP;
                        end else if (hcnt_q == TYPE_HI && i_rx_data != ETHERTYPE[15:8]) begin
                            state_d = DROP;
                        end else if (hcnt_q == HDR_LAST) begin
                            state_d = (i_rx_data == ETHERTYPE[7:0]) ? PAYLOAD : DROP;
                        end
                    end
                    PAYLOAD: begin
                        if (full) begin
                            wr_d    = commit_q;
                            drop_d  = i_rx_eof;
                            state_d = i_rx_eof ? IDLE : DROP;
                        end else if (i_rx_eof && i_rx_err) begin
                            wr_d    = commit_q;
                            drop_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ram_we = 1'b1;
                            wr_d   = wr_q + ptr_t'(1);
                            if (i_rx_eof) begin
                                commit_d = wr_q + ptr_t'(1);
                                state_d  = IDLE;
                            end
                        end
                    end
                    DROP: begin
                        if (i_rx_eof) begin
                            drop_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            mac_ok_q <= 1'b0;
            bc_ok_q  <= 1'b0;
            wr_q     <= '0;
            commit_q <= '0;
            rd_q     <= '0;
            drop_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            mac_ok_q <= mac_ok_d;
            bc_ok_q  <= bc_ok_d;
            wr_q     <= wr_d;
            commit_q <= commit_d;
            rd_q     <= rd_d;
            drop_q   <= drop_d;
            // RAM reads mem[rd_d] on this same edge, so ready and data line up next cycle
            rdy_q    <= (commit_q != rd_d);
        end
    end

    eth_rx_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_waddr (wr_q[ADDR_W-1:0]),
        .i_wdata (i_rx_data),
        .i_raddr (rd_d[ADDR_W-1:0]),
        .o_rdata (ram_q)
    );

    assign o_rdata  = rdy_q ? ram_q : '0;
    assign o_rready = rdy_q;
    assign o_drop   = drop_q;

`ifdef ETH_RX_STATS_EN
    logic [15:0] good_cnt_q, drop_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            good_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (commit_d != commit_q) good_cnt_q <= sat_inc16(good_cnt_q);
            if (drop_d)               drop_cnt_q <= sat_inc16(drop_cnt_q);
        end
    end

    assign o_good_cnt = good_cnt_q;
    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_good_cnt = '0;
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_rx_deframer.sv
// Scoreboard bench for eth_rx_deframer with a frame-level acceptance model.
module tb_eth_rx_deframer;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;
    localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
    localparam logic [15:0] ETYPE  = 16'h88B5;
    localparam logic [47:0] BCAST  = 48'hFF_FF_FF_FF_FF_FF;

    logic        i_clk      = 1'b0;
    logic        i_rst_n    = 1'b0;
    logic [7:0]  i_rx_data  = '0;
    logic        i_rx_valid = 1'b0;
    logic        i_rx_sof   = 1'b0;
    logic        i_rx_eof   = 1'b0;
    logic        i_rx_err   = 1'b0;
    logic        i_rreq     = 1'b0;
    logic [7:0]  o_rdata;
    logic        o_rready;
    logic        o_drop;
    logic [15:0] o_drop_cnt;
    logic [15:0] o_good_cnt;

    always #5 i_clk = ~i_clk;

    eth_rx_deframer #(
        .ADDR_W    (ADDR_W),
        .MY_MAC    (MY_MAC),
        .ETHERTYPE (ETYPE)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .i_rx_sof   (i_rx_sof),
        .i_rx_eof   (i_rx_eof),
        .i_rx_err   (i_rx_err),
        .o_rdata    (o_rdata),
        .o_rready   (o_rready),
        .i_rreq     (i_rreq),
        .o_drop     (o_drop),
        .o_drop_cnt (o_drop_cnt),
        .o_good_cnt (o_good_cnt)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] frm[$];
    int         exp_good = 0;
    int         exp_drop = 0;
    int         seen_drop = 0;
    bit         pending_abort = 1'b0;
    int         rd_mode = 0;
    bit         gaps = 1'b0;
    logic [7:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // reader: 0 = idle, 1 = random pops, 2 = pop every cycle
    initial forever begin
        @(posedge i_clk);
        #1;
        case (rd_mode)
            0:       i_rreq = 1'b0;
            1:       i_rreq = 1'($urandom_range(0, 1));
            default: i_rreq = 1'b1;
        endcase
    end

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_drop) seen_drop++;
            if (o_rready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_empty: o_rready=1 o_rdata=%0h with nothing committed", o_rdata);
                end else if (i_rreq) begin
                    mon_e = exp_q.pop_front();
                    chk("pop_data", {24'h0, o_rdata}, {24'h0, mon_e});
                end else begin
                    chk("head_hold", {24'h0, o_rdata}, {24'h0, exp_q[0]});
                end
            end
        end
    end

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] et,
                               input int plen, input logic [7:0] first, input bit incr);
        logic [47:0] d;
        frm.delete();
        d = dst;
        for (int i = 0; i < 6; i++) begin
            frm.push_back(d[47:40]);
            d = d << 8;
        end
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(incr ? 8'(first + 8'(i)) : 8'($urandom));
    endtask

    function automatic bit accept(input bit err, input int room);
        logic [47:0] dst;
        logic [15:0] et;
        if (frm.size() < 15) return 1'b0;
        dst = '0;
        for (int i = 0; i < 6; i++) dst = {dst[39:0], frm[i]};
        et = {frm[12], frm[13]};
        return (dst == MY_MAC || dst == BCAST) && et == ETYPE && !err && (frm.size() - 14 <= room);
    endfunction

    task automatic idle_drive();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
        i_rx_sof   = 1'($urandom_range(0, 1));
        i_rx_eof   = 1'($urandom_range(0, 1));
        i_rx_err   = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input bit with_eof, input bit err);
        int room;
        room = DEPTH - exp_q.size();
        if (pending_abort) exp_drop++;
        pending_abort = !with_eof;
        for (int i = 0; i < frm.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge i_clk);
                    #1;
                    idle_drive();
                end
            end
            @(posedge i_clk);
            #1;
            i_rx_valid = 1'b1;
            i_rx_data  = frm[i];
            i_rx_sof   = (i == 0);
            i_rx_eof   = with_eof && (i == frm.size() - 1);
            i_rx_err   = i_rx_eof ? err : 1'($urandom_range(0, 1));
        end
        @(posedge i_clk);
        #1;
        idle_drive();
        if (with_eof) begin
            if (accept(err, room)) begin
                for (int i = 14; i < frm.size(); i++) exp_q.push_back(frm[i]);
                exp_good++;
            end else begin
                exp_drop++;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(posedge i_clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic check_counters(input string tag);
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        chk({tag, "_drop_pulses"}, seen_drop, exp_drop);
`ifdef ETH_RX_STATS_EN
        chk({tag, "_good_cnt"}, {16'h0, o_good_cnt}, exp_good);
        chk({tag, "_drop_cnt"}, {16'h0, o_drop_cnt}, exp_drop);
`else
        chk({tag, "_good_cnt"}, {16'h0, o_good_cnt}, 0);
        chk({tag, "_drop_cnt"}, {16'h0, o_drop_cnt}, 0);
`endif
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        idle_drive();
        exp_q.delete();
        exp_good = 0;
        exp_drop = 0;
        seen_drop = 0;
        pending_abort = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        int w;
        int plen;
        int r;
        logic [47:0] dst;
        logic [15:0] et;

        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("reset_rready", o_rready, 0);
        chk("reset_rdata", o_rdata, 0);
        chk("reset_drop", o_drop, 0);
        chk("reset_good_cnt", o_good_cnt, 0);
        chk("reset_drop_cnt", o_drop_cnt, 0);

        // good 46-byte frame, ready latency then drain
        build_frame(MY_MAC, ETYPE, 46, 8'h01, 1'b1);
        send_frame(1'b1, 1'b0);
        lat = -1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            if (o_rready && lat < 0) lat = k;
        end
        chk("rready_latency_ok", (lat >= 0 && lat <= 2), 1);
        rd_mode = 1;
        drain();
        check_counters("t1");

        // filtered frames and a broadcast frame
        build_frame(MY_MAC, 16'h0800, 20, 8'h00, 1'b0);
        send_frame(1'b1, 1'b0);
        build_frame(48'h02_00_00_00_00_02, ETYPE, 20, 8'h00, 1'b0);
        send_frame(1'b1, 1'b0);
        build_frame(BCAST, ETYPE, 20, 8'h30, 1'b1);
        send_frame(1'b1, 1'b0);
        drain();
        check_counters("t2");

        // errored frame followed by a good one
        build_frame(MY_MAC, ETYPE, 20, 8'h60, 1'b1);
        send_frame(1'b1, 1'b1);
        build_frame(MY_MAC, ETYPE, 46, 8'h40, 1'b1);
        send_frame(1'b1, 1'b0);
        drain();
        check_counters("t3");

        // overflow drop, exact fill, then overflow while full
        rd_mode = 0;
        repeat (3) @(posedge i_clk);
        build_frame(MY_MAC, ETYPE, 70, 8'h00, 1'b0);
        send_frame(1'b1, 1'b0);
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        chk("ovf_empty_rready", o_rready, 0);
        build_frame(MY_MAC, ETYPE, 64, 8'h80, 1'b1);
        send_frame(1'b1, 1'b0);
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        chk("full_rready", o_rready, 1);
        chk("full_no_drop", seen_drop, exp_drop);
        build_frame(MY_MAC, ETYPE, 1, 8'hEE, 1'b1);
        send_frame(1'b1, 1'b0);
        rd_mode = 1;
        drain();
        check_counters("t4");

        // sof mid-payload aborts frame A
        build_frame(MY_MAC, ETYPE, 30, 8'h10, 1'b1);
        send_frame(1'b0, 1'b0);
        build_frame(MY_MAC, ETYPE, 25, 8'hA0, 1'b1);
        send_frame(1'b1, 1'b0);
        drain();
        check_counters("t5");

        // continuous pops during commit and on empty
        rd_mode = 2;
        build_frame(BCAST, ETYPE, 40, 8'h05, 1'b1);
        send_frame(1'b1, 1'b0);
        drain();
        repeat (6) @(posedge i_clk);
        check_counters("t6");

        // reset mid-frame with committed data pending
        rd_mode = 0;
        build_frame(MY_MAC, ETYPE, 10, 8'hC0, 1'b1);
        send_frame(1'b1, 1'b0);
        repeat (3) @(posedge i_clk);
        build_frame(MY_MAC, ETYPE, 30, 8'h00, 1'b0);
        send_frame(1'b0, 1'b0);
        do_reset();
        @(negedge i_clk);
        chk("rst_mid_rready", o_rready, 0);
        chk("rst_mid_good_cnt", o_good_cnt, 0);
        rd_mode = 1;
        build_frame(MY_MAC, ETYPE, 12, 8'h70, 1'b1);
        send_frame(1'b1, 1'b0);
        drain();
        check_counters("t6r");

        // randomized traffic
        gaps = 1'b1;
        for (int f = 0; f < 150; f++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: dst = MY_MAC;
                4, 5:       dst = BCAST;
                6:          dst = 48'h02_00_00_00_00_02;
                7:          dst = 48'h02_FF_FF_FF_FF_FF;
                default:    dst = {16'h0200, 32'($urandom)};
            endcase
            et = ($urandom_range(0, 4) != 0) ? ETYPE : 16'($urandom);
            plen = $urandom_range(1, 40);
            build_frame(dst, et, plen, 8'h00, 1'b0);
            w = 0;
            while (exp_q.size() + plen > DEPTH && w < 1000) begin
                @(posedge i_clk);
                w++;
            end
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(2, 14);
                while (frm.size() > r) frm.delete(frm.size() - 1);
                send_frame(1'b1, 1'b0);
            end else if ($urandom_range(0, 15) == 0) begin
                send_frame(1'b0, 1'b0);
            end else begin
                send_frame(1'b1, ($urandom_range(0, 7) == 0));
            end
        end
        build_frame(MY_MAC, ETYPE, 8, 8'hF0, 1'b1);
        send_frame(1'b1, 1'b0);
        drain();
        check_counters("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
